// File: rtl/ras.sv
// ras: circular return address stack with checkpoint restore for the fetch predictor
module ras #(
  parameter int RAS_ENTRIES = 8,
  parameter int RAS_INDEX_WIDTH = 3,
  parameter int RAS_TARGET_WIDTH = 31
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        pred_req_valid,
  input  logic                        pred_req_push,
  input  logic [RAS_TARGET_WIDTH-1:0] pred_req_push_target,
  input  logic                        pred_req_pop,
  output logic                        pred_ret_valid,
  output logic [RAS_TARGET_WIDTH-1:0] pred_ret_target,
  output logic [RAS_INDEX_WIDTH-1:0]  pred_ras_index,
  output logic [RAS_INDEX_WIDTH:0]    pred_ras_count,
  input  logic                        update_valid,
  input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index,
  input  logic [RAS_INDEX_WIDTH:0]    update_ras_count
);
  localparam logic [RAS_INDEX_WIDTH:0] FULL = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);
  logic [RAS_TARGET_WIDTH-1:0] stack [RAS_ENTRIES];
  logic [RAS_INDEX_WIDTH-1:0] ptr, ptr_nxt, wr_idx;
  logic [RAS_INDEX_WIDTH:0] count, count_nxt;
  logic op, push, pop, wr_en;
  always_comb begin
    op = pred_req_valid & ~update_valid;
    push = op & pred_req_push & ~pred_req_pop;
    pop = op & pred_req_pop & ~pred_req_push;
    wr_en = op & pred_req_push;
    wr_idx = pred_req_pop ? ptr : ptr + 1'b1;
    ptr_nxt = update_valid ? update_ras_index : push ? ptr + 1'b1 : pop ? ptr - 1'b1 : ptr;
    count_nxt = update_valid ? (update_ras_count > FULL ? FULL : update_ras_count)
              : push ? (count == FULL ? FULL : count + 1'b1)
              : pop ? (count == '0 ? '0 : count - 1'b1)
              : count;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= '1;
      count <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) stack[i] <= '0;
    end else begin
      ptr <= ptr_nxt;
      count <= count_nxt;
      if (wr_en) stack[wr_idx] <= pred_req_push_target;
    end
  end
  assign pred_ret_target = stack[ptr];
  assign pred_ret_valid = pred_req_valid & pred_req_pop & (count != '0);
  assign pred_ras_index = ptr;
  assign pred_ras_count = count;
endmodule

// File: tb/tb_ras.sv
// tb_ras: directed and randomized checks of ras against an arithmetic stack model
module tb_ras;
  logic CLK = 0, RST = 0;
  logic pred_req_valid = 0, pred_req_push = 0, pred_req_pop = 0, update_valid = 0;
  logic [30:0] pred_req_push_target = 0, pred_ret_target;
  logic pred_ret_valid;
  logic [2:0] pred_ras_index, update_ras_index = 0;
  logic [3:0] pred_ras_count, update_ras_count = 0;
  int passed = 0, total = 0;
  int m_ptr, m_cnt;
  logic [30:0] m_stk [8];
  always #5 CLK = ~CLK;
  ras dut (
    .CLK(CLK), .RST(RST),
    .pred_req_valid(pred_req_valid), .pred_req_push(pred_req_push),
    .pred_req_push_target(pred_req_push_target), .pred_req_pop(pred_req_pop),
    .pred_ret_valid(pred_ret_valid), .pred_ret_target(pred_ret_target),
    .pred_ras_index(pred_ras_index), .pred_ras_count(pred_ras_count),
    .update_valid(update_valid), .update_ras_index(update_ras_index),
    .update_ras_count(update_ras_count)
  );
  task automatic drive(input logic v, pu, po, input logic [30:0] t, input logic u, input logic [2:0] ui, input logic [3:0] uc);
    pred_req_valid = v; pred_req_push = pu; pred_req_pop = po; pred_req_push_target = t;
    update_valid = u; update_ras_index = ui; update_ras_count = uc;
    #1;
  endtask
  // model advances from the inputs about to be sampled, then the DUT clocks
  task automatic tick();
    if (RST) begin
      m_ptr = 7; m_cnt = 0;
      foreach (m_stk[i]) m_stk[i] = '0;
    end else if (update_valid) begin
      m_ptr = update_ras_index; m_cnt = update_ras_count > 8 ? 8 : update_ras_count;
    end else if (pred_req_valid) begin
      if (pred_req_push && pred_req_pop) m_stk[m_ptr] = pred_req_push_target;
      else if (pred_req_push) begin
        m_ptr = (m_ptr + 1) % 8; m_stk[m_ptr] = pred_req_push_target; m_cnt = m_cnt == 8 ? 8 : m_cnt + 1;
      end else if (pred_req_pop) begin
        m_ptr = (m_ptr + 7) % 8; m_cnt = m_cnt == 0 ? 0 : m_cnt - 1;
      end
    end
    @(posedge CLK); #1;
    RST = 0; pred_req_valid = 0; pred_req_push = 0; pred_req_pop = 0; update_valid = 0;
  endtask
  task automatic do_reset();
    RST = 1; drive(0, 0, 0, 0, 0, 0, 0); tick();
  endtask
  task automatic push(input logic [30:0] t);
    drive(1, 1, 0, t, 0, 0, 0); tick();
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (pred_ras_index !== 3'd7) $display("FAIL reset_index got %0d want 7", pred_ras_index); else passed++;
    total++; if (pred_ras_count !== 4'd0) $display("FAIL reset_count got %0d want 0", pred_ras_count); else passed++;
    total++; if (pred_ret_target !== 31'd0) $display("FAIL reset_target got %h want 0", pred_ret_target); else passed++;
    drive(1, 0, 1, 0, 0, 0, 0);
    total++; if (pred_ret_valid !== 1'b0) $display("FAIL empty_pop_valid got %b want 0", pred_ret_valid); else passed++;
    tick();
    total++; if (pred_ras_index !== 3'd6) $display("FAIL empty_pop_index got %0d want 6", pred_ras_index); else passed++;
    total++; if (pred_ras_count !== 4'd0) $display("FAIL empty_pop_count got %0d want 0", pred_ras_count); else passed++;
  endtask
  task automatic test_lifo();
    logic [30:0] exp [3] = '{31'h3000, 31'h2000, 31'h1000};
    push(31'h1000); push(31'h2000); push(31'h3000);
    total++; if (pred_ras_count !== 4'd3) $display("FAIL lifo_count got %0d want 3", pred_ras_count); else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0);
      total++; if (pred_ret_target !== exp[i] || pred_ret_valid !== 1'b1)
        $display("FAIL lifo_pop%0d got %h/%b want %h/1", i, pred_ret_target, pred_ret_valid, exp[i]); else passed++;
      tick();
    end
    total++; if (pred_ras_count !== 4'd0) $display("FAIL lifo_drain_count got %0d want 0", pred_ras_count); else passed++;
    drive(1, 0, 1, 0, 0, 0, 0);
    total++; if (pred_ret_valid !== 1'b0) $display("FAIL lifo_underflow got %b want 0", pred_ret_valid); else passed++;
    tick();
  endtask
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) push(31'h100 + 31'(i));
    total++; if (pred_ras_count !== 4'd8) $display("FAIL ovf_count got %0d want 8", pred_ras_count); else passed++;
    for (int i = 9; i >= 2; i--) begin
      drive(1, 0, 1, 0, 0, 0, 0);
      total++; if (pred_ret_target !== 31'h100 + 31'(i) || pred_ret_valid !== 1'b1)
        $display("FAIL ovf_pop_T%0d got %h/%b want %h/1", i, pred_ret_target, pred_ret_valid, 31'h100 + 31'(i)); else passed++;
      tick();
    end
    drive(1, 0, 1, 0, 0, 0, 0);
    total++; if (pred_ret_valid !== 1'b0) $display("FAIL ovf_ninth_pop got %b want 0", pred_ret_valid); else passed++;
    tick();
  endtask
  task automatic test_swap();
    do_reset();
    push(31'hA);
    drive(1, 1, 1, 31'hB, 0, 0, 0);
    total++; if (pred_ret_target !== 31'hA || pred_ret_valid !== 1'b1)
      $display("FAIL swap_ret got %h/%b want a/1", pred_ret_target, pred_ret_valid); else passed++;
    tick();
    total++; if (pred_ras_index !== 3'd0 || pred_ras_count !== 4'd1)
      $display("FAIL swap_state got %0d/%0d want 0/1", pred_ras_index, pred_ras_count); else passed++;
    drive(1, 0, 1, 0, 0, 0, 0);
    total++; if (pred_ret_target !== 31'hB || pred_ret_valid !== 1'b1)
      $display("FAIL swap_pop got %h/%b want b/1", pred_ret_target, pred_ret_valid); else passed++;
    tick();
    total++; if (pred_ras_count !== 4'd0) $display("FAIL swap_drain got %0d want 0", pred_ras_count); else passed++;
  endtask
  task automatic test_restore();
    logic [2:0] ck_idx;
    logic [3:0] ck_cnt;
    do_reset();
    push(31'h11); push(31'h22);
    ck_idx = pred_ras_index; ck_cnt = pred_ras_count;
    total++; if (ck_idx !== 3'd1 || ck_cnt !== 4'd2) $display("FAIL ckpt got %0d/%0d want 1/2", ck_idx, ck_cnt); else passed++;
    push(31'h33);
    drive(1, 0, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, ck_idx, ck_cnt); tick();
    drive(1, 0, 1, 0, 0, 0, 0);
    total++; if (pred_ret_target !== 31'h22 || pred_ret_valid !== 1'b1)
      $display("FAIL restore_pop got %h/%b want 22/1", pred_ret_target, pred_ret_valid); else passed++;
    tick();
    total++; if (pred_ras_count !== 4'd1) $display("FAIL restore_count got %0d want 1", pred_ras_count); else passed++;
  endtask
  task automatic test_update_priority();
    do_reset();
    drive(1, 1, 1, 31'h55, 1, 3'd4, 4'd3); tick();
    total++; if (pred_ras_index !== 3'd4 || pred_ras_count !== 4'd3)
      $display("FAIL upd_prio_state got %0d/%0d want 4/3", pred_ras_index, pred_ras_count); else passed++;
    drive(1, 1, 0, 31'h55, 1, 3'd4, 4'd3); tick();
    drive(0, 0, 0, 0, 1, 3'd5, 4'd1); tick();
    total++; if (pred_ret_target !== 31'd0) $display("FAIL upd_prio_stack5 got %h want 0", pred_ret_target); else passed++;
    total++; if (pred_ras_index !== 3'd5) $display("FAIL upd_prio_index got %0d want 5", pred_ras_index); else passed++;
    drive(0, 0, 0, 0, 1, 3'd2, 4'd12); tick();
    total++; if (pred_ras_count !== 4'd8) $display("FAIL upd_sat_count got %0d want 8", pred_ras_count); else passed++;
  endtask
  task automatic test_reset_mid();
    push(31'h66); push(31'h67);
    RST = 1; drive(1, 1, 0, 31'h99, 1, 3'd3, 4'd2); tick();
    total++; if (pred_ras_index !== 3'd7 || pred_ras_count !== 4'd0 || pred_ret_target !== 31'd0)
      $display("FAIL rst_mid got %0d/%0d/%h want 7/0/0", pred_ras_index, pred_ras_count, pred_ret_target); else passed++;
    push(31'h77);
    total++; if (pred_ras_index !== 3'd0 || pred_ras_count !== 4'd1 || pred_ret_target !== 31'h77)
      $display("FAIL rst_first_push got %0d/%0d/%h want 0/1/77", pred_ras_index, pred_ras_count, pred_ret_target); else passed++;
  endtask
  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      RST = $urandom_range(0, 99) == 0;
      drive($urandom_range(0, 3) != 0, 1'($urandom()), 1'($urandom()), 31'($urandom()),
            $urandom_range(0, 9) == 0, 3'($urandom()), 4'($urandom()));
      total++; if (pred_ras_index !== 3'(m_ptr) || pred_ras_count !== 4'(m_cnt) || pred_ret_target !== m_stk[m_ptr] ||
                   pred_ret_valid !== (pred_req_valid & pred_req_pop & (m_cnt != 0)))
        $display("FAIL rand_%0d got %0d/%0d/%h/%b want %0d/%0d/%h/%b", n, pred_ras_index, pred_ras_count, pred_ret_target,
                 pred_ret_valid, m_ptr, m_cnt, m_stk[m_ptr], pred_req_valid & pred_req_pop & (m_cnt != 0)); else passed++;
      tick();
    end
  endtask
  initial begin
    @(posedge CLK); #1;
    test_reset();
    test_lifo();
    test_overflow();
    test_swap();
    test_restore();
    test_update_priority();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
